// File: rtl/multiplier_sequencer_tt.sv
// Taint-tracked issue/retire sequencer around the sequential multiplier.
// Defining MULT_SEQ_TIMEOUT_EN adds a WAIT-state watchdog that aborts to IDLE.
module multiplier_sequencer_tt #(
    parameter int unsigned WIDTH   = 256,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_valid_t,
    output logic                   in_ready,
    output logic                   in_ready_t,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_a_t,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [WIDTH-1:0]       in_b_t,
    output logic                   start,
    output logic                   start_t,
    output logic [WIDTH-1:0]       multiplier,
    output logic [WIDTH-1:0]       multiplier_t,
    output logic [WIDTH-1:0]       multiplicand,
    output logic [WIDTH-1:0]       multiplicand_t,
    input  logic [2*WIDTH-1:0]     product,
    input  logic [2*WIDTH-1:0]     product_t,
    input  logic                   productDone,
    input  logic                   productDone_t,
    output logic                   out_valid,
    output logic                   out_valid_t,
    input  logic                   out_ready,
    input  logic                   out_ready_t,
    output logic [2*WIDTH-1:0]     out_product,
    output logic [2*WIDTH-1:0]     out_product_t,
    output logic                   timeout_err,
    output logic                   timeout_err_t
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, HOLD = 2'd3} state_e;

    state_e            state_q, state_d;
    logic              st_t_q, st_t_d;
    logic              first_q, first_d;
    logic [WIDTH-1:0]  a_q, a_d, a_t_q, a_t_d;
    logic [WIDTH-1:0]  b_q, b_d, b_t_q, b_t_d;
    logic [PW-1:0]     prod_q, prod_d, prod_t_q, prod_t_d;

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            st_t_q   <= 1'b0;
            first_q  <= 1'b0;
            a_q      <= '0;
            a_t_q    <= '0;
            b_q      <= '0;
            b_t_q    <= '0;
            prod_q   <= '0;
            prod_t_q <= '0;
`ifdef MULT_SEQ_TIMEOUT_EN
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            st_t_q   <= st_t_d;
            first_q  <= first_d;
            a_q      <= a_d;
            a_t_q    <= a_t_d;
            b_q      <= b_d;
            b_t_q    <= b_t_d;
            prod_q   <= prod_d;
            prod_t_q <= prod_t_d;
`ifdef MULT_SEQ_TIMEOUT_EN
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    // Next state; st_t accumulates the taint of every deciding or stalling condition
    always_comb begin
        state_d  = state_q;
        st_t_d   = st_t_q;
        first_d  = 1'b0;
        a_d      = a_q;
        a_t_d    = a_t_q;
        b_d      = b_q;
        b_t_d    = b_t_q;
        prod_d   = prod_q;
        prod_t_d = prod_t_q;
`ifdef MULT_SEQ_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                st_t_d = st_t_q | in_valid_t;
                if (in_valid) begin
                    state_d = START;
                    a_d     = in_a;
                    a_t_d   = in_a_t;
                    b_d     = in_b;
                    b_t_d   = in_b_t;
                end
            end
            START: begin
                state_d = WAIT;
                first_d = 1'b1;
`ifdef MULT_SEQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // first_q masks a stale done left over from the previous operation
                if (!first_q && productDone) begin
                    state_d  = HOLD;
                    st_t_d   = st_t_q | productDone_t;
                    prod_d   = product;
                    prod_t_d = product_t;
                end else begin
                    if (!first_q) begin
                        st_t_d = st_t_q | productDone_t;
                    end
`ifdef MULT_SEQ_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = IDLE;
                        tmo_d   = 1'b1;
                    end
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    st_t_d  = out_ready_t;
                end else begin
                    st_t_d  = st_t_q | out_ready_t;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            START:   start     = 1'b1;
            HOLD:    out_valid = 1'b1;
            default: ;
        endcase
    end

    assign in_ready_t     = st_t_q;
    assign start_t        = st_t_q;
    assign out_valid_t    = st_t_q;
    assign multiplier     = a_q;
    assign multiplier_t   = a_t_q;
    assign multiplicand   = b_q;
    assign multiplicand_t = b_t_q;
    assign out_product    = prod_q;
    assign out_product_t  = prod_t_q;

`ifdef MULT_SEQ_TIMEOUT_EN
    assign timeout_err    = tmo_q;
    assign timeout_err_t  = st_t_q;
`else
    assign timeout_err    = 1'b0;
    assign timeout_err_t  = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_sequencer_tt.sv
// Scoreboard bench for multiplier_sequencer_tt (WIDTH=8, TIMEOUT=4); the bench
// plays the multiplier, and a negedge monitor checks each retired result.
module tb_multiplier_sequencer_tt;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid_t, in_ready, in_ready_t;
    logic [7:0]  in_a, in_a_t, in_b, in_b_t;
    logic        start, start_t;
    logic [7:0]  multiplier, multiplier_t, multiplicand, multiplicand_t;
    logic [15:0] product, product_t;
    logic        productDone, productDone_t;
    logic        out_valid, out_valid_t, out_ready, out_ready_t;
    logic [15:0] out_product, out_product_t;
    logic        timeout_err, timeout_err_t;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] pt;
        logic        vt;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    sb_entry_t mon_e;

    multiplier_sequencer_tt #(.WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_valid_t(in_valid_t),
        .in_ready(in_ready), .in_ready_t(in_ready_t),
        .in_a(in_a), .in_a_t(in_a_t), .in_b(in_b), .in_b_t(in_b_t),
        .start(start), .start_t(start_t),
        .multiplier(multiplier), .multiplier_t(multiplier_t),
        .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
        .product(product), .product_t(product_t),
        .productDone(productDone), .productDone_t(productDone_t),
        .out_valid(out_valid), .out_valid_t(out_valid_t),
        .out_ready(out_ready), .out_ready_t(out_ready_t),
        .out_product(out_product), .out_product_t(out_product_t),
        .timeout_err(timeout_err), .timeout_err_t(timeout_err_t)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Retired results are compared against the scoreboard on the handshake cycle
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got out_product 0x%0h expected no result", out_product);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_product", 32'(out_product), 32'(mon_e.p));
                chk("out_product_t", 32'(out_product_t), 32'(mon_e.pt));
                chk("out_valid_t", 32'(out_valid_t), 32'(mon_e.vt));
            end
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] at, input logic [7:0] b,
                          input logic [7:0] bt, input logic vt, input logic [15:0] p,
                          input logic [15:0] pt, input logic et, input int stall,
                          input logic ort);
        int w;
        sb_q.push_back(sb_entry_t'{p: p, pt: pt, vt: et});
        in_valid = 1'b1; in_valid_t = vt;
        in_a = a; in_a_t = at; in_b = b; in_b_t = bt;
        w = 0;
        while (!in_ready && w < 20) begin
            cyc();
            w++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        cyc();
        chk("start", 32'(start), 32'd1);
        chk("start_t", 32'(start_t), 32'(et));
        chk("multiplier", 32'(multiplier), 32'(a));
        chk("multiplier_t", 32'(multiplier_t), 32'(at));
        chk("multiplicand", 32'(multiplicand), 32'(b));
        chk("multiplicand_t", 32'(multiplicand_t), 32'(bt));
        chk("busy_not_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; in_valid_t = 1'b0;
        cyc();
        chk("start_one_cycle", 32'(start), 32'd0);
        productDone = 1'b1; product = 16'hDEAD; product_t = 16'h0000;
        cyc();
        chk("stale_done_masked", 32'(out_valid), 32'd0);
        product = p; product_t = pt;
        cyc();
        productDone = 1'b0; product = '0; product_t = '0;
        for (int i = 0; i < stall; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_product", 32'(out_product), 32'(p));
            chk("hold_no_accept", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1; out_ready_t = ort;
        cyc();
        out_ready = 1'b0; out_ready_t = 1'b0;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready_t", 32'(in_ready_t), 32'(ort));
        chk("product_kept", 32'(out_product), 32'(p));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_valid_t = 0; in_a = 0; in_a_t = 0; in_b = 0; in_b_t = 0;
        product = 0; product_t = 0; productDone = 0; productDone_t = 0;
        out_ready = 0; out_ready_t = 0;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_in_ready_t", 32'(in_ready_t), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_out_product", 32'(out_product), 32'd0);
        rst = 1'b0;
        cyc();

        // a, a_t, b, b_t, in_valid_t, product, product_t, exp ctrl taint, stall, out_ready_t
        run_op(8'd13,  8'h00, 8'd11,  8'h00, 1'b0, 16'd143,  16'h0000, 1'b0, 0, 1'b0);
        run_op(8'd5,   8'h01, 8'd3,   8'h00, 1'b0, 16'd15,   16'h0003, 1'b0, 0, 1'b0);
        run_op(8'hFF,  8'h00, 8'hFF,  8'h00, 1'b1, 16'hFE01, 16'h0000, 1'b1, 1, 1'b0);
        run_op(8'd200, 8'h00, 8'd3,   8'h00, 1'b0, 16'd600,  16'h0000, 1'b0, 5, 1'b0);
        run_op(8'd0,   8'h80, 8'hFF,  8'hFF, 1'b0, 16'd0,    16'hFFFF, 1'b0, 2, 1'b1);
        run_op(8'd1,   8'h00, 8'd1,   8'h00, 1'b0, 16'd1,    16'h0000, 1'b1, 0, 1'b0);

        // Reset abandons an operation sitting in WAIT
        in_valid = 1'b1; in_valid_t = 1'b1; in_a = 8'd7; in_b = 8'd9;
        cyc();
        in_valid = 1'b0; in_valid_t = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready_t", 32'(in_ready_t), 32'd0);
        chk("mid_rst_out_valid_t", 32'(out_valid_t), 32'd0);
        chk("mid_rst_multiplier", 32'(multiplier), 32'd0);
        chk("mid_rst_out_product", 32'(out_product), 32'd0);
        productDone = 1'b1; product = 16'h003F;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        productDone = 1'b0; product = '0;

`ifdef MULT_SEQ_TIMEOUT_EN
        in_valid = 1'b1; in_a = 8'd3; in_b = 8'd3;
        cyc();
        in_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("tmo_quiet", 32'(timeout_err), 32'd0);
            cyc();
        end
        chk("tmo_still_wait", 32'(in_ready), 32'd0);
        cyc();
        chk("tmo_pulse", 32'(timeout_err), 32'd1);
        chk("tmo_in_ready", 32'(in_ready), 32'd1);
        chk("tmo_product_kept", 32'(out_product), 32'd0);
        cyc();
        chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
`else
        chk("timeout_err_tied", 32'(timeout_err), 32'd0);
`endif

        cyc();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
